uart_word_tx: RTL and testbench

Parametrised RS232 word transmitter. It accepts a multi-byte word from the device manager over a valid/ready handshake and serialises it LSB-byte-first as standard UART frames (start, data, optional parity, stop) on a single TXD line. An internal baud counter paces the bits. `busy` and `done` carry device status back to the device manager.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_word_tx_if.sv | 24 ++
 rtl/uart_baud_counter.sv | 34 +++
 rtl/uart_word_tx.sv | 180 ++++++++++++++++++
 tb/tb_uart_word_tx.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART word transmitter and the
// planned receiver.
//   tx_state_t                : transmitter FSM states
//   uart_frame_bits()         : bits per frame (start + data + parity + stop)
//   UART_CLKS_PER_BIT_115200  : clocks per bit for 115200 baud at 50 MHz
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT_115200 = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int unsigned uart_frame_bits(input int unsigned data_bits,
                                                  input int unsigned parity_en,
                                                  input int unsigned stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// uart_word_tx_if: word handshake and status between the device manager and
// the UART word transmitter.
//   in_valid  manager -> tx   word presented
//   in_data   manager -> tx   word to send (WIDTH bits)
//   in_ready  tx -> manager   transmitter idle, word can be accepted
//   busy      tx -> manager   word in progress
//   done      tx -> manager   one-cycle pulse at end of word
interface uart_word_tx_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             busy;
  logic             done;

  modport master (output in_valid, output in_data,
                  input  in_ready, input  busy, input done);

  modport slave  (input  in_valid, input  in_data,
                  output in_ready, output busy, output done);

endinterface

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: bit-period pacing counter.
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   enable  in   count while high; counter held at 0 while low
//   tick    out  high on the terminal count (last cycle of a bit)
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: RS232 word transmitter. Accepts a WORD_BYTES*DATA_BITS word
// over a valid/ready handshake and sends it LSB byte first, LSB bit first,
// as start / data / [parity] / stop frames with no gap between frames.
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of uart_word_tx_if (in_valid, in_data, in_ready,
//          busy, done)
//   txd    out  registered serial line, idles high
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_word_tx_if.slave  bus,
  output logic           txd
);

  localparam int unsigned WORD_W = WORD_BYTES * DATA_BITS;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam int unsigned BYTE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  if (CLKS_PER_BIT < 2) begin : gChkClks
    $error("uart_word_tx: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : gChkData
    $error("uart_word_tx: DATA_BITS must be 5..8");
  end
  if (WORD_BYTES < 1) begin : gChkBytes
    $error("uart_word_tx: WORD_BYTES must be >= 1");
  end
  if (PARITY_EN > 1 || PARITY_ODD > 1) begin : gChkParity
    $error("uart_word_tx: PARITY_EN and PARITY_ODD must be 0 or 1");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gChkStop
    $error("uart_word_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_t         state, stateNext;
  logic              tick;
  logic [WORD_W-1:0] shiftReg;
  logic [BIT_W-1:0]  bitIdx;
  logic              stopIdx;
  logic [BYTE_W-1:0] byteIdx;
  logic              parityBit;
  logic              txdNext, doneNext;
  logic              busyQ, doneQ;
  logic              lastBit, lastStop, lastByte;

  assign lastBit  = (bitIdx == BIT_W'(DATA_BITS - 1));
  assign lastStop = (stopIdx == 1'(STOP_BITS - 1));
  assign lastByte = (byteIdx == BYTE_W'(WORD_BYTES - 1));

  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = busyQ;
  assign bus.done     = doneQ;

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state != IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      txd   <= 1'b1;
      busyQ <= 1'b0;
      doneQ <= 1'b0;
    end else begin
      state <= stateNext;
      txd   <= txdNext;
      busyQ <= (stateNext != IDLE);
      doneQ <= doneNext;
    end
  end

  // txd is registered from the line level of the next state, so the start
  // bit appears the cycle after accept and each level lasts a full bit.
  always_comb begin
    stateNext = state;
    txdNext   = 1'b1;
    doneNext  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          stateNext = START;
          txdNext   = 1'b0;
        end
      end
      START: begin
        txdNext = 1'b0;
        if (tick) begin
          stateNext = DATA;
          txdNext   = shiftReg[0];
        end
      end
      DATA: begin
        txdNext = shiftReg[0];
        if (tick) begin
          if (!lastBit) begin
            txdNext = shiftReg[1];
          end else if (PARITY_EN != 0) begin
            stateNext = PARITY;
            txdNext   = parityBit;
          end else begin
            stateNext = STOP;
            txdNext   = 1'b1;
          end
        end
      end
      PARITY: begin
        txdNext = parityBit;
        if (tick) begin
          stateNext = STOP;
          txdNext   = 1'b1;
        end
      end
      STOP: begin
        txdNext = 1'b1;
        if (tick && lastStop) begin
          if (lastByte) begin
            stateNext = IDLE;
            doneNext  = 1'b1;
          end else begin
            stateNext = START;
            txdNext   = 1'b0;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shiftReg  <= '0;
      bitIdx    <= '0;
      stopIdx   <= 1'b0;
      byteIdx   <= '0;
      parityBit <= 1'b0;
    end else begin
      if (state == IDLE) begin
        bitIdx  <= '0;
        stopIdx <= 1'b0;
        byteIdx <= '0;
        if (bus.in_valid) shiftReg <= bus.in_data;
      end else if (tick) begin
        case (state)
          DATA: begin
            // Shifting the whole word leaves the next byte at the bottom.
            shiftReg <= shiftReg >> 1;
            bitIdx   <= lastBit ? '0 : bitIdx + 1'b1;
          end
          STOP: begin
            if (lastStop) begin
              stopIdx <= 1'b0;
              byteIdx <= lastByte ? '0 : byteIdx + 1'b1;
            end else begin
              stopIdx <= stopIdx + 1'b1;
            end
          end
          default: ;
        endcase
      end
      // The current byte sits untouched in the low bits throughout START.
      if (state == START) begin
        parityBit <= (^shiftReg[DATA_BITS-1:0]) ^ PARITY_ODD[0];
      end
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;
  import uart_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned NDUT = 4;
  localparam int unsigned WB [NDUT] = '{4, 1, 1, 2};
  localparam int unsigned PE [NDUT] = '{0, 1, 1, 0};
  localparam int unsigned PO [NDUT] = '{0, 0, 1, 0};
  localparam int unsigned SB [NDUT] = '{1, 1, 1, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA = 1'b0;
  logic rstB = 1'b0;
  logic        validV [NDUT];
  logic [31:0] dataV  [NDUT];
  logic txdV [NDUT], busyV [NDUT], doneV [NDUT], readyV [NDUT];

  int tests = 0;
  int fails = 0;

  uart_word_tx_if #(.WIDTH(32)) bus0 ();
  uart_word_tx_if #(.WIDTH(8))  bus1 ();
  uart_word_tx_if #(.WIDTH(8))  bus2 ();
  uart_word_tx_if #(.WIDTH(16)) bus3 ();

  assign bus0.in_valid = validV[0];
  assign bus1.in_valid = validV[1];
  assign bus2.in_valid = validV[2];
  assign bus3.in_valid = validV[3];
  assign bus0.in_data  = dataV[0];
  assign bus1.in_data  = dataV[1][7:0];
  assign bus2.in_data  = dataV[2][7:0];
  assign bus3.in_data  = dataV[3][15:0];
  assign busyV[0] = bus0.busy;  assign doneV[0] = bus0.done;  assign readyV[0] = bus0.in_ready;
  assign busyV[1] = bus1.busy;  assign doneV[1] = bus1.done;  assign readyV[1] = bus1.in_ready;
  assign busyV[2] = bus2.busy;  assign doneV[2] = bus2.done;  assign readyV[2] = bus2.in_ready;
  assign busyV[3] = bus3.busy;  assign doneV[3] = bus3.done;  assign readyV[3] = bus3.in_ready;

  uart_word_tx #(.CLKS_PER_BIT(N)) dut0 (
    .clk(clk), .rst_n(rstA), .bus(bus0.slave), .txd(txdV[0]));
  uart_word_tx #(.CLKS_PER_BIT(N), .WORD_BYTES(1), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst_n(rstB), .bus(bus1.slave), .txd(txdV[1]));
  uart_word_tx #(.CLKS_PER_BIT(N), .WORD_BYTES(1), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst_n(rstB), .bus(bus2.slave), .txd(txdV[2]));
  uart_word_tx #(.CLKS_PER_BIT(N), .WORD_BYTES(2), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst_n(rstB), .bus(bus3.slave), .txd(txdV[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Line level of serial bit k of a word (bit 0 = first start bit).
  function automatic logic expBit(input int unsigned idx, input logic [31:0] w,
                                  input int unsigned k);
    int unsigned f;
    int unsigned fr;
    int unsigned b;
    logic [31:0] sh;
    logic [7:0]  by;
    f  = uart_frame_bits(8, PE[idx], SB[idx]);
    fr = k / f;
    b  = k % f;
    sh = w >> (8 * fr);
    by = sh[7:0];
    if (b == 0) return 1'b0;
    if (b <= 8) return by[b-1];
    if (PE[idx] != 0 && b == 9) return (^by) ^ (PO[idx] != 0);
    return 1'b1;
  endfunction

  function automatic int unsigned wordCycles(input int unsigned idx);
    return WB[idx] * uart_frame_bits(8, PE[idx], SB[idx]) * N;
  endfunction

  // Reference model: an active word runs for wordCycles() cycles from the
  // cycle after accept; done follows on the first idle cycle.
  logic        mAct  [NDUT];
  logic        mDone [NDUT];
  int unsigned mCyc  [NDUT];
  logic [31:0] mWord [NDUT];

  always @(negedge clk) begin : model
    logic r;
    logic expTxd;
    for (int i = 0; i < NDUT; i++) begin
      r = (i == 0) ? rstA : rstB;
      if (!r) begin
        mAct[i]  = 1'b0;
        mDone[i] = 1'b0;
        mCyc[i]  = 0;
      end
      expTxd = mAct[i] ? expBit(i, mWord[i], mCyc[i] / N) : 1'b1;
      check($sformatf("dut%0d txd cyc%0d", i, mCyc[i]), {31'b0, txdV[i]}, {31'b0, expTxd});
      check($sformatf("dut%0d busy", i), {31'b0, busyV[i]}, {31'b0, mAct[i]});
      check($sformatf("dut%0d in_ready", i), {31'b0, readyV[i]}, {31'b0, ~mAct[i]});
      check($sformatf("dut%0d done", i), {31'b0, doneV[i]}, {31'b0, mDone[i]});
      if (r) begin
        mDone[i] = 1'b0;
        if (mAct[i]) begin
          mCyc[i]++;
          if (mCyc[i] == wordCycles(i)) begin
            mAct[i]  = 1'b0;
            mDone[i] = 1'b1;
          end
        end else if (validV[i]) begin
          mAct[i]  = 1'b1;
          mWord[i] = dataV[i];
          mCyc[i]  = 0;
        end
      end
    end
  end

  task automatic acceptWord(input int unsigned idx, input logic [31:0] w);
    @(posedge clk); #1;
    validV[idx] = 1'b1;
    dataV[idx]  = w;
    @(posedge clk); #1;
    validV[idx] = 1'b0;
  endtask

  // Called in cycle T+1: samples each bit mid-period against pat, counts
  // high cycles over those bits and locates the done pulse.
  task automatic frameCheck(input int unsigned idx, input logic [11:0] pat,
                            input int unsigned nBits, input int unsigned highExp,
                            input int unsigned doneAt, input string name);
    int unsigned first = 0;
    int unsigned cnt = 0;
    int unsigned highs = 0;
    int unsigned m;
    for (int unsigned n = 1; n <= doneAt + 8; n++) begin
      @(negedge clk);
      m = n - 1;
      if (m / N < nBits) begin
        if (txdV[idx]) highs++;
        if (m % N == 1)
          check($sformatf("%s bit%0d", name, m / N), {31'b0, txdV[idx]}, {31'b0, pat[m/N]});
      end
      if (doneV[idx]) begin
        if (first == 0) first = n;
        cnt++;
      end
    end
    check({name, " high cycles"}, highs, highExp);
    check({name, " done cycle"}, first, doneAt);
    check({name, " done pulses"}, cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no summary after 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned first;
    for (int i = 0; i < NDUT; i++) begin
      validV[i] = 1'b0;
      dataV[i]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rstA = 1'b1;
    rstB = 1'b1;
    repeat (2) @(posedge clk);

    // Pin the model with hand-computed values.
    for (int unsigned j = 0; j < 10; j++) begin
      logic [9:0] p;
      p = 10'b11_0000_0010;
      check($sformatf("model frame0 bit%0d", j), {31'b0, expBit(0, 32'hA5C30F81, j)}, {31'b0, p[j]});
    end
    check("model even parity", {31'b0, expBit(1, 32'h07, 9)}, 1);
    check("model odd parity", {31'b0, expBit(2, 32'h07, 9)}, 0);
    check("model word cycles", wordCycles(0), 160);

    // Basic word: bytes 81 0F C3 A5.
    acceptWord(0, 32'hA5C30F81);
    frameCheck(0, 12'b0011_0000_0010, 10, 12, 161, "basic");

    // Parity, 0x07: even -> 1, odd -> 0.
    acceptWord(1, 32'h07);
    frameCheck(1, 12'b0110_0000_1110, 11, 20, 45, "even parity");
    acceptWord(2, 32'h07);
    frameCheck(2, 12'b0100_0000_1110, 11, 16, 45, "odd parity");

    // Two stop bits, 0x0000: 8 high cycles, then the next start bit.
    acceptWord(3, 32'h0000);
    frameCheck(3, 12'b0110_0000_0000, 12, 8, 89, "two stop");

    // Back-to-back with in_valid held and in_data changed mid-word.
    @(posedge clk); #1;
    validV[0] = 1'b1;
    dataV[0]  = 32'h11223344;
    @(posedge clk); #1;
    dataV[0]  = 32'hDEADBEEF;
    for (int unsigned n = 1; n <= 161; n++) begin
      @(negedge clk);
      if (n == 60) begin
        #1;
        dataV[0] = 32'h55667788;
      end
    end
    check("b2b ready on done cycle", {31'b0, readyV[0]}, 1);
    check("b2b done on done cycle", {31'b0, doneV[0]}, 1);
    @(posedge clk); #1;
    validV[0] = 1'b0;
    @(negedge clk);
    check("b2b second start txd", {31'b0, txdV[0]}, 0);
    check("b2b second busy", {31'b0, busyV[0]}, 1);
    first = 0;
    for (int unsigned n = 2; n <= 175; n++) begin
      @(negedge clk);
      if (doneV[0] && first == 0) first = n;
    end
    check("b2b second done cycle", first, 161);

    // Reset during byte 2, data bit 3 (serial bit 24, a 0 in 0xC3).
    acceptWord(0, 32'hA5C30F81);
    repeat (98) @(negedge clk);
    check("pre-reset txd", {31'b0, txdV[0]}, 0);
    #1;
    rstA = 1'b0;
    #1;
    check("reset txd", {31'b0, txdV[0]}, 1);
    check("reset busy", {31'b0, busyV[0]}, 0);
    check("reset in_ready", {31'b0, readyV[0]}, 1);
    check("reset done", {31'b0, doneV[0]}, 0);
    repeat (2) @(posedge clk);
    #1;
    rstA = 1'b1;
    acceptWord(0, 32'h5A5A5AFF);
    frameCheck(0, 12'b0011_1111_1110, 10, 36, 161, "post-reset");

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
